// File: rtl/cpu_system_pkg.sv
// Shared types for the SAP-style CPU system: data/address types, opcodes,
// core phase and system control states.
package cpu_system_pkg;

    typedef logic [7:0] byte_t;
    typedef logic [3:0] addr_t;

    localparam int CPU_OUT_DEPTH_DEF = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_OUT = 4'h6,
        OP_JMP = 4'h7,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic {
        PH_FETCH,
        PH_EXEC
    } core_phase_t;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_RUN,
        ST_HALT
    } cpu_sys_state_t;

endpackage

// File: rtl/cpu_core.sv
// Two-phase (fetch/execute) accumulator CPU. reset_i is a synchronous hold,
// clk_en_i advances one phase per enabled clock.
module cpu_core import cpu_system_pkg::*; (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  reset_i,
    input  logic  clk_en_i,
    input  byte_t mem_data_i,
    output addr_t mem_addr_o,
    output logic  out_strobe_o,
    output byte_t out_value_o,
    output logic  hlt_o
);

    core_phase_t phase;
    addr_t       pc;
    byte_t       ir;
    byte_t       acc;
    logic        halted;
    opcode_t     op;

    assign op = opcode_t'(ir[7:4]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= PH_FETCH;
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            halted <= 1'b0;
        end else if (reset_i) begin
            phase  <= PH_FETCH;
            pc     <= '0;
            ir     <= '0;
            acc    <= '0;
            halted <= 1'b0;
        end else if (clk_en_i && !halted) begin
            if (phase == PH_FETCH) begin
                ir    <= mem_data_i;
                pc    <= pc + 1'b1;
                phase <= PH_EXEC;
            end else begin
                phase <= PH_FETCH;
                case (op)
                    OP_LDA:  acc    <= mem_data_i;
                    OP_ADD:  acc    <= acc + mem_data_i;
                    OP_SUB:  acc    <= acc - mem_data_i;
                    OP_JMP:  pc     <= ir[3:0];
                    OP_HLT:  halted <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign mem_addr_o   = (phase == PH_FETCH) ? pc : ir[3:0];
    assign out_strobe_o = (phase == PH_EXEC) && (op == OP_OUT) && !halted;
    assign out_value_o  = acc;
    assign hlt_o        = halted;

endmodule

// File: rtl/cpu_mem.sv
// 2**ADDR_W x 8 program/data RAM: asynchronous read, write on the falling clock edge.
module cpu_mem import cpu_system_pkg::*; #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  byte_t             wdata,
    output byte_t             rdata
);

    byte_t ram [2**ADDR_W];

    // NOTE: storage arrays get no reset; contents must survive a system reset
    // and a reset port would turn the array into a bank of resettable flops.
    always_ff @(negedge clk) begin
        if (we) begin
            ram[addr] <= wdata;
        end
    end

    assign rdata = ram[addr];

endmodule

// File: rtl/cpu_out_fifo.sv
// Byte FIFO for CPU output values; a push into a full FIFO only lands when a
// pop frees a slot in the same cycle.
module cpu_out_fifo import cpu_system_pkg::*; #(
    parameter int DEPTH = CPU_OUT_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  byte_t                    push_data,
    input  logic                     pop,
    input  logic                     flush,
    output byte_t                    head_data,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int PTR_W = $clog2(DEPTH);

    byte_t             storage [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign valid   = (count != '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

    // Empty FIFO presents zero rather than a stale entry.
    assign head_data = valid ? storage[rd_ptr] : '0;

endmodule

// File: rtl/cpu_system.sv
// CPU system top: streaming program loader, run/halt control and a buffered
// valid/ready output drain around cpu_core and cpu_mem.
module cpu_system import cpu_system_pkg::*; #(
    parameter int MEM_ADDR_W = 4,
    parameter int OUT_DEPTH  = CPU_OUT_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n_i,
    input  logic                       clk_en_i,
    input  logic                       load_valid_i,
    input  logic [7:0]                 load_data_i,
    input  logic                       load_last_i,
    output logic                       load_ready_o,
    input  logic                       reload_i,
    output logic                       run_o,
    output logic                       halt_o,
    output logic                       out_valid_o,
    output logic [7:0]                 out_data_o,
    input  logic                       out_ready_i,
    output logic [$clog2(OUT_DEPTH):0] out_count_o,
    output logic                       out_overflow_o
);

    if (MEM_ADDR_W != $bits(addr_t)) begin : g_bad_addr_w
        $error("cpu_system: MEM_ADDR_W must equal $bits(addr_t)");
    end
    if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("cpu_system: OUT_DEPTH must be a power of two >= 2");
    end

    localparam logic [MEM_ADDR_W-1:0] LOAD_ADDR_MAX = '1;

    cpu_sys_state_t          state;
    logic [MEM_ADDR_W-1:0]   load_addr;
    logic                    load_fire, load_done, reload_fire;
    logic                    core_reset, core_hlt, core_strobe;
    byte_t                   core_value, mem_rdata, mem_wdata;
    addr_t                   core_addr, mem_addr;
    logic                    mem_we;
    logic                    fifo_push, fifo_pop, fifo_full;

    assign load_ready_o = (state == ST_LOAD);
    assign load_fire    = load_valid_i && load_ready_o;
    assign load_done    = load_fire && (load_last_i || load_addr == LOAD_ADDR_MAX);
    assign reload_fire  = reload_i && (state != ST_LOAD);
    assign core_reset   = (state == ST_LOAD);
    assign fifo_push    = (state == ST_RUN) && core_strobe && clk_en_i;
    assign fifo_pop     = out_valid_o && out_ready_i;

    // NOTE: every signal driven here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = core_addr;
        mem_wdata = '0;
        if (state == ST_LOAD) begin
            mem_we    = load_valid_i;
            mem_addr  = addr_t'(load_addr);
            mem_wdata = load_data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= ST_LOAD;
            load_addr <= '0;
            run_o     <= 1'b0;
            halt_o    <= 1'b0;
        end else begin
            unique case (state)
                ST_LOAD: if (load_fire) begin
                    load_addr <= load_addr + 1'b1;
                    if (load_done) begin
                        state <= ST_RUN;
                        run_o <= 1'b1;
                    end
                end
                ST_RUN: if (reload_fire) begin
                    state     <= ST_LOAD;
                    load_addr <= '0;
                    run_o     <= 1'b0;
                end else if (core_hlt) begin
                    state  <= ST_HALT;
                    halt_o <= 1'b1;
                end
                ST_HALT: if (reload_fire) begin
                    state     <= ST_LOAD;
                    load_addr <= '0;
                    run_o     <= 1'b0;
                    halt_o    <= 1'b0;
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            out_overflow_o <= 1'b0;
        end else if (reload_fire) begin
            out_overflow_o <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            out_overflow_o <= 1'b1;
        end
    end

    cpu_core u_core (
        .clk          (clk),
        .rst_n        (reset_n_i),
        .reset_i      (core_reset),
        .clk_en_i     (clk_en_i),
        .mem_data_i   (mem_rdata),
        .mem_addr_o   (core_addr),
        .out_strobe_o (core_strobe),
        .out_value_o  (core_value),
        .hlt_o        (core_hlt)
    );

    cpu_mem #(.ADDR_W(MEM_ADDR_W)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .rdata (mem_rdata)
    );

    cpu_out_fifo #(.DEPTH(OUT_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset_n_i),
        .push      (fifo_push),
        .push_data (core_value),
        .pop       (fifo_pop),
        .flush     (reload_fire),
        .head_data (out_data_o),
        .valid     (out_valid_o),
        .count     (out_count_o),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_cpu_system.sv
// Scenario bench for cpu_system: program load/run/halt, full-address load,
// output FIFO saturation and overflow, reload and mid-load reset.
module tb_cpu_system;
    import cpu_system_pkg::*;

    localparam int DEPTH = 4;

    logic                     clk = 1'b0;
    logic                     reset_n_i, clk_en_i, load_valid_i, load_last_i, reload_i, out_ready_i;
    logic [7:0]               load_data_i;
    logic                     load_ready_o, run_o, halt_o, out_valid_o, out_overflow_o;
    logic [7:0]               out_data_o;
    logic [$clog2(DEPTH):0]   out_count_o;

    int    checks = 0;
    int    errors = 0;
    byte_t exp_q[$];

    always #5 clk = ~clk;

    cpu_system #(.MEM_ADDR_W(4), .OUT_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n_i      (reset_n_i),
        .clk_en_i       (clk_en_i),
        .load_valid_i   (load_valid_i),
        .load_data_i    (load_data_i),
        .load_last_i    (load_last_i),
        .load_ready_o   (load_ready_o),
        .reload_i       (reload_i),
        .run_o          (run_o),
        .halt_o         (halt_o),
        .out_valid_o    (out_valid_o),
        .out_data_o     (out_data_o),
        .out_ready_i    (out_ready_i),
        .out_count_o    (out_count_o),
        .out_overflow_o (out_overflow_o)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input byte_t d, input logic last);
        load_valid_i = 1'b1;
        load_data_i  = d;
        load_last_i  = last;
        tick(1);
        load_valid_i = 1'b0;
        load_last_i  = 1'b0;
    endtask

    task automatic pulse_reload();
        reload_i = 1'b1;
        tick(1);
        reload_i = 1'b0;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; clk_en_i = 1'b1; load_valid_i = 1'b0; load_data_i = '0;
        load_last_i = 1'b0; reload_i = 1'b0; out_ready_i = 1'b0;
        #3;
        checks++;
        if ({load_ready_o, run_o, halt_o, out_valid_o, out_count_o, out_overflow_o, out_data_o}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b run=%b halt=%b vld=%b cnt=%0d ovf=%b data=%h want 1 0 0 0 0 0 00",
                     load_ready_o, run_o, halt_o, out_valid_o, out_count_o, out_overflow_o, out_data_o);
        end
        #9 reset_n_i = 1'b1;
        tick(1);
    endtask

    // 16-byte load without last: HLT at 0, operands at 14/15 for later programs.
    task automatic test_full_load();
        byte_t img [16];
        int    n;
        foreach (img[i]) img[i] = 8'h00;
        img[0] = 8'hF0; img[14] = 8'h1C; img[15] = 8'h0E;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++;
                if (load_ready_o !== 1'b1 || run_o !== 1'b0) begin
                    errors++;
                    $display("FAIL full_before_last: rdy=%b run=%b want 1 0", load_ready_o, run_o);
                end
            end
            load_byte(img[i], 1'b0);
        end
        checks++;
        if (run_o !== 1'b1 || load_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_exit: run=%b rdy=%b want 1 0", run_o, load_ready_o);
        end
        n = 0;
        while (halt_o !== 1'b1 && n < 20) begin
            tick(1); n++;
            checks++;
            if (load_ready_o !== 1'b0) begin
                errors++;
                $display("FAIL full_ready_low: rdy=%b want 0", load_ready_o);
            end
        end
        checks++;
        if (halt_o !== 1'b1 || out_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL full_halt: halt=%b vld=%b want 1 0", halt_o, out_valid_o);
        end
    endtask

    // LDA 14 / ADD 15 / OUT / HLT  ->  0x1C + 0x0E = 0x2A
    task automatic test_program();
        byte_t prog [4] = '{8'h1E, 8'h2F, 8'h60, 8'hF0};
        byte_t e;
        int    n;
        pulse_reload();
        checks++;
        if (load_ready_o !== 1'b1 || run_o !== 1'b0 || halt_o !== 1'b0) begin
            errors++;
            $display("FAIL prog_reload: rdy=%b run=%b halt=%b want 1 0 0", load_ready_o, run_o, halt_o);
        end
        exp_q.push_back(8'h2A);
        for (int i = 0; i < 4; i++) load_byte(prog[i], i == 3);
        checks++;
        if (run_o !== 1'b1) begin
            errors++;
            $display("FAIL prog_run: run=%b want 1", run_o);
        end
        n = 0;
        while (out_valid_o !== 1'b1 && n < 30) begin tick(1); n++; end
        e = exp_q.pop_front();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== e) begin
            errors++;
            $display("FAIL prog_out: vld=%b data=%h want 1 %h", out_valid_o, out_data_o, e);
        end
        out_ready_i = 1'b1; tick(1); out_ready_i = 1'b0;
        n = 0;
        while (halt_o !== 1'b1 && n < 30) begin tick(1); n++; end
        checks++;
        if (halt_o !== 1'b1 || out_count_o !== 3'd0 || out_overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL prog_halt: halt=%b cnt=%0d ovf=%b want 1 0 0", halt_o, out_count_o, out_overflow_o);
        end
    endtask

    // Loop ADD 15 / OUT / JMP 0 emits 0x0E*k every 6 enabled clocks, first at
    // the 4th clock after the last load byte.
    task automatic test_overflow();
        byte_t prog [3] = '{8'h2F, 8'h60, 8'h70};
        byte_t e;
        pulse_reload();
        out_ready_i = 1'b0;
        for (int k = 1; k <= 4; k++) exp_q.push_back(byte_t'(14 * k));
        for (int i = 0; i < 3; i++) load_byte(prog[i], i == 2);
        tick(22);
        checks++;
        if (out_count_o !== 3'd4 || out_overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fill: cnt=%0d ovf=%b want 4 0", out_count_o, out_overflow_o);
        end
        tick(6);
        checks++;
        if (out_count_o !== 3'd4 || out_overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: cnt=%0d ovf=%b want 4 1", out_count_o, out_overflow_o);
        end
        exp_q.push_back(byte_t'(14 * 6));
        tick(5);
        // Pop lands on the same edge as the 6th push.
        e = exp_q.pop_front();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== e) begin
            errors++;
            $display("FAIL ovf_pushpop_head: vld=%b data=%h want 1 %h", out_valid_o, out_data_o, e);
        end
        out_ready_i = 1'b1; tick(1); out_ready_i = 1'b0;
        clk_en_i = 1'b0;
        checks++;
        if (out_count_o !== 3'd4) begin
            errors++;
            $display("FAIL ovf_pushpop_count: cnt=%0d want 4", out_count_o);
        end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (out_valid_o !== 1'b1 || out_data_o !== e) begin
                errors++;
                $display("FAIL ovf_drain%0d: vld=%b data=%h want 1 %h", i, out_valid_o, out_data_o, e);
            end
            out_ready_i = 1'b1; tick(1); out_ready_i = 1'b0;
        end
        checks++;
        if (out_valid_o !== 1'b0 || out_count_o !== 3'd0 || out_overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL ovf_empty: vld=%b cnt=%0d ovf=%b want 0 0 1", out_valid_o, out_count_o, out_overflow_o);
        end
    endtask

    task automatic test_reload();
        int n = 0;
        clk_en_i = 1'b1;
        while (out_count_o !== 3'd2 && n < 40) begin tick(1); n++; end
        checks++;
        if (out_count_o !== 3'd2 || run_o !== 1'b1) begin
            errors++;
            $display("FAIL reload_pre: cnt=%0d run=%b want 2 1", out_count_o, run_o);
        end
        pulse_reload();
        checks++;
        if ({run_o, load_ready_o, out_count_o, out_overflow_o, out_valid_o} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reload_post: run=%b rdy=%b cnt=%0d ovf=%b vld=%b want 0 1 0 0 0",
                     run_o, load_ready_o, out_count_o, out_overflow_o, out_valid_o);
        end
    endtask

    // HLT bytes at 0..4 before the reset; a loader that failed to restart at
    // address 0 would leave a HLT in front of the program.
    task automatic test_reset_midload();
        byte_t prog [4] = '{8'h1E, 8'h2F, 8'h60, 8'hF0};
        byte_t e;
        int    n;
        for (int i = 0; i < 5; i++) load_byte(8'hF0, 1'b0);
        #2 reset_n_i = 1'b0;
        #1;
        checks++;
        if ({load_ready_o, run_o, halt_o, out_valid_o, out_count_o, out_overflow_o, out_data_o}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00}) begin
            errors++;
            $display("FAIL midload_reset: rdy=%b run=%b halt=%b vld=%b cnt=%0d ovf=%b data=%h want 1 0 0 0 0 0 00",
                     load_ready_o, run_o, halt_o, out_valid_o, out_count_o, out_overflow_o, out_data_o);
        end
        #2 reset_n_i = 1'b1;
        tick(1);
        exp_q.push_back(8'h2A);
        for (int i = 0; i < 4; i++) load_byte(prog[i], i == 3);
        n = 0;
        while (out_valid_o !== 1'b1 && n < 30) begin tick(1); n++; end
        e = exp_q.pop_front();
        checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== e) begin
            errors++;
            $display("FAIL midload_addr0: vld=%b data=%h want 1 %h", out_valid_o, out_data_o, e);
        end
        out_ready_i = 1'b1; tick(1); out_ready_i = 1'b0;
        n = 0;
        while (halt_o !== 1'b1 && n < 30) begin tick(1); n++; end
        checks++;
        if (halt_o !== 1'b1 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midload_halt: halt=%b pending=%0d want 1 0", halt_o, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_program();
        test_overflow();
        test_reload();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cpu_system.md
# cpu_system

Parametrised successor to the SAP system top. It wraps `cpu_core` and `cpu_mem` and adds three things the CPU does not have on its own: a streaming program loader, a run/halt control FSM, and an output FIFO with a valid/ready drain. A host or UART bridge can download a program, start it, collect every `OUT` value without loss, and reload without a global reset. It sits between board-level glue and the CPU/memory pair.

## Interface
Parameters:
- `MEM_ADDR_W`, default 4: RAM address width. Must equal `$bits(addr_t)`; elaboration error otherwise.
- `OUT_DEPTH`, default 4: output FIFO depth. Power of two, at least 2.

Ports:
- `clk`  in  1: system clock; the only clock.
- `reset_n_i`  in  1: reset, asynchronous and active-low.
- `clk_en_i`  in  1: CPU step enable, passed to the core. The loader and FIFO ignore it.
- `load_valid_i`  in  1: loader byte valid.
- `load_data_i`  in  8: loader byte.
- `load_last_i`  in  1: marks the final byte; qualified by `load_valid_i`.
- `load_ready_o`  out  1: loader ready.
- `reload_i`  in  1: single-cycle request to return to LOAD.
- `run_o`  out  1: CPU released from reset.
- `halt_o`  out  1: program has halted.
- `out_valid_o`  out  1: FIFO head valid.
- `out_data_o`  out  8: FIFO head value.
- `out_ready_i`  in  1: consumer pop.
- `out_count_o`  out  `$clog2(OUT_DEPTH)+1`: FIFO occupancy.
- `out_overflow_o`  out  1: sticky flag, set when a CPU output was dropped.

## Operation
- FSM states: `ST_LOAD`, `ST_RUN`, `ST_HALT`. The reset state is `ST_LOAD`.
- Reset values: `load_ready_o`=1, `run_o`=0, `halt_o`=0, `out_valid_o`=0, `out_count_o`=0, `out_overflow_o`=0, `out_data_o`=0, load address=0.
- **ST_LOAD**
  - Core `reset_i` is held at 1.
  - Memory port is muxed to the loader: `we` = `load_valid_i`, `addr` = load address, `data` = `load_data_i`.
  - A handshake is `load_valid_i & load_ready_o`. Each handshake writes one byte and increments the load address.
  - Exit to `ST_RUN` on a handshake with `load_last_i`=1, or on a handshake at address `2**MEM_ADDR_W-1`.
  - Addresses that are not written keep their old RAM contents.
- **ST_RUN**
  - `run_o`=1, core `reset_i`=0, memory port is muxed to the core.
  - Core `hlt_o`=1 moves the FSM to `ST_HALT`.
- **ST_HALT**
  - `halt_o`=1. The core is left unreset and stays halted by itself.
- **Reload**
  - `reload_i` in `ST_RUN` or `ST_HALT` moves the FSM to `ST_LOAD`, clears the load address, flushes the FIFO and clears `out_overflow_o`.
  - `reload_i` in `ST_LOAD` is ignored.
  - When both happen in the same cycle, `reload_i` has priority over core `hlt_o`.
- **FIFO push**
  - Push condition: core `out_strobe_o & clk_en_i` while in `ST_RUN`. The pushed value is `out_value_o`.
  - If the FIFO is full and there is no pop in the same cycle, the value is dropped and `out_overflow_o` is set.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted and the count is unchanged.
- **FIFO pop**
  - Pop condition: `out_valid_o & out_ready_i`.
  - `out_data_o` = head entry; `out_valid_o` = (count != 0).
  - Pointers are `$clog2(OUT_DEPTH)` bits and wrap modulo `OUT_DEPTH`.

## Timing
- All block flops reset asynchronously on the falling edge of `reset_n_i` and release on the next `clk` rising edge.
- `reset_n_i` asserted mid-operation aborts any load or run immediately. RAM contents are not cleared.
- A loader byte is written on the falling edge inside its handshake cycle (RAM is negedge-clocked).
- `run_o` rises on the clock after the final load handshake. The core's first fetch uses the first `clk_en_i` after that.
- `halt_o` rises one clock after core `hlt_o`.
- Push to `out_valid_o` latency: 1 clock from an empty FIFO.
- Pop effect (head advance, count decrement) is visible on the next clock.
- `load_ready_o` is a combinational decode of registered state; there is no input-to-output combinational path.

## Structure
- Add to `cpu_package.svh`:
  - `cpu_sys_state_t` enum (`ST_LOAD`, `ST_RUN`, `ST_HALT`).
  - Localparam `CPU_OUT_DEPTH_DEF`=4.
  - Reuse the existing `byte_t` and `addr_t`.
- One sub-module, `cpu_out_fifo`, parameterised on `DEPTH` and width 8. Ports: push, push data, pop, flush, head data, valid, count, full.
- The FSM, loader counter, memory mux and overflow flag stay in `cpu_system`.

## Test plan
- Load 0x1E, 0x2F, 0x60, 0xF0 (LDA 14 / ADD 15 / OUT / HLT idiom), last on the 4th byte, plus RAM[14]=0x1C and RAM[15]=0x0E written by a second load. Expected: `run_o`=1 one clock after the last byte, FIFO yields 0x2A, then `halt_o`=1.
- Load all 16 bytes without `load_last_i`. Expected: transition to `ST_RUN` after the byte at address 15, and `load_ready_o`=0 from then on.
- Output loop program with `out_ready_i`=0 and `OUT_DEPTH`=4. Expected: `out_count_o` saturates at 4, the 5th output sets `out_overflow_o`, and the first 4 values are intact in order.
- FIFO full with push and pop in the same cycle. Expected: `out_count_o` stays 4 and the new value appears after 3 further pops.
- `reload_i` pulsed while running with FIFO count 2. Expected: next cycle `run_o`=0, `load_ready_o`=1, count 0, overflow 0.
- `reset_n_i` pulsed low mid-load at address 5. Expected: outputs at reset values immediately, and the next handshake writes address 0.
